// File: rtl/dla_cmd_seq_pkg.sv
// Shared types, register map and opcode helpers for the DLA command sequencer.
package dla_cmd_seq_pkg;

    typedef enum logic [2:0] {
        OpRsvd0   = 3'd0,
        OpDdr2gb  = 3'd1,
        OpGb2lb   = 3'd2,
        OpConv    = 3'd3,
        OpFc      = 3'd4,
        OpApe     = 3'd5,
        OpReshape = 3'd6,
        OpRsvd7   = 3'd7
    } seq_op_e;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitUnit,
        StWaitLpe,
        StFinish
    } seq_state_e;

    // Register map offsets and SEQ_CTRL / SEQ_STATUS bit positions
    localparam logic [7:0]  SeqCmdAddr        = 8'h40;
    localparam logic [7:0]  SeqCtrlAddr       = 8'h44;
    localparam logic [7:0]  SeqStatusAddr     = 8'h48;
    localparam logic [7:0]  SeqDoneCntAddr    = 8'h4c;
    localparam int unsigned SeqCtrlEnBit      = 0;
    localparam int unsigned SeqCtrlFlushBit   = 1;
    localparam int unsigned SeqStatLevelLsb   = 0;
    localparam int unsigned SeqStatBusyBit    = 8;
    localparam int unsigned SeqStatOvfErrBit  = 9;
    localparam int unsigned SeqStatOpErrBit   = 10;

    function automatic logic op_legal(input logic [2:0] op);
        return (op != 3'd0) && (op != 3'd7);
    endfunction

    function automatic logic op_needs_lpe(input seq_op_e op);
        return (op == OpConv) || (op == OpFc) || (op == OpReshape);
    endfunction

endpackage

// File: rtl/dla_cmd_fifo.sv
// Synchronous command FIFO with flush; flush beats any push or pop in the same cycle.
module dla_cmd_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 3,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [LW-1:0]    level
);

    localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full    = (level_q == FullLevel);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop & ~empty & ~flush;
    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push & ~flush & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/dla_cmd_seq.sv
// Command sequencer: pops opcodes, issues one go pulse each and waits for completion.
module dla_cmd_seq
    import dla_cmd_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_wen,
    input  logic [2:0]             cmd_wdata,
    input  logic                   seq_en,
    input  logic                   seq_flush,
    output logic                   go_mov_ddr2gb,
    output logic                   go_mov_gb2lb,
    output logic                   go_comp_conv,
    output logic                   go_comp_fc,
    output logic                   go_comp_ape,
    output logic                   go_comp_reshape,
    input  logic                   complete_mov_ddr2gb,
    input  logic                   complete_mov_gb2lb,
    input  logic                   complete_comp_conv,
    input  logic                   complete_comp_fc,
    input  logic                   complete_comp_ape,
    input  logic                   complete_comp_reshape,
    input  logic                   complete_lpe,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   busy,
    output logic [CNT_W-1:0]       done_cnt,
    output logic                   seq_done,
    output logic                   ovf_err,
    output logic                   op_err
);

    seq_state_e       state_q, state_d;
    seq_op_e          cur_op_q, cur_op_d;
    logic [CNT_W-1:0] done_cnt_q;
    logic             ovf_err_q, op_err_q;
    logic             pop, op_err_set, unit_done;
    logic             fifo_full, fifo_empty;
    logic [2:0]       head;

    dla_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (3)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cmd_wen),
        .pop   (pop),
        .flush (seq_flush),
        .wdata (cmd_wdata),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        unit_done = 1'b0;
        case (cur_op_q)
            OpDdr2gb:  unit_done = complete_mov_ddr2gb;
            OpGb2lb:   unit_done = complete_mov_gb2lb;
            OpConv:    unit_done = complete_comp_conv;
            OpFc:      unit_done = complete_comp_fc;
            OpApe:     unit_done = complete_comp_ape;
            OpReshape: unit_done = complete_comp_reshape;
            default:   unit_done = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cur_op_d   = cur_op_q;
        pop        = 1'b0;
        op_err_set = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Flush wins over a pop in the same cycle
                if (seq_en && !fifo_empty && !seq_flush) begin
                    pop = 1'b1;
                    if (op_legal(head)) begin
                        cur_op_d = seq_op_e'(head);
                        state_d  = StIssue;
                    end else begin
                        op_err_set = 1'b1;
                    end
                end
            end
            StIssue:    state_d = StWaitUnit;
            StWaitUnit: begin
                if (unit_done) state_d = op_needs_lpe(cur_op_q) ? StWaitLpe : StFinish;
            end
            StWaitLpe:  if (complete_lpe) state_d = StFinish;
            StFinish:   state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cur_op_q   <= OpRsvd0;
            done_cnt_q <= '0;
            ovf_err_q  <= 1'b0;
            op_err_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cur_op_q <= cur_op_d;
            if (state_q == StFinish) done_cnt_q <= done_cnt_q + 1'b1;
            // A push dropped by a flush is not an overflow
            if (cmd_wen && !seq_flush && fifo_full && !pop) ovf_err_q <= 1'b1;
            if (op_err_set) op_err_q <= 1'b1;
        end
    end

    assign go_mov_ddr2gb   = (state_q == StIssue) && (cur_op_q == OpDdr2gb);
    assign go_mov_gb2lb    = (state_q == StIssue) && (cur_op_q == OpGb2lb);
    assign go_comp_conv    = (state_q == StIssue) && (cur_op_q == OpConv);
    assign go_comp_fc      = (state_q == StIssue) && (cur_op_q == OpFc);
    assign go_comp_ape     = (state_q == StIssue) && (cur_op_q == OpApe);
    assign go_comp_reshape = (state_q == StIssue) && (cur_op_q == OpReshape);

    assign busy     = (state_q != StIdle);
    assign done_cnt = done_cnt_q;
    assign seq_done = (state_q == StFinish) && fifo_empty;
    assign ovf_err  = ovf_err_q;
    assign op_err   = op_err_q;

endmodule
